ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 82 ++++++++
 tb/tb_ctrl_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control-path pipeline registers (EX/MEM/WB) with load-use stall, branch/jump flush
// and a saturating count of inserted bubbles.
module ctrl_pipe #(
   parameter int BUBBLE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [8:0]          id_ctrl,
   input  logic                id_valid,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   input  logic [4:0]          id_rd,
   input  logic                ex_branch_taken,
   output logic [8:0]          ex_ctrl,
   output logic [4:0]          ex_rd,
   output logic                mem_regwrite,
   output logic                mem_memtoreg,
   output logic                mem_memread,
   output logic                mem_memwrite,
   output logic [4:0]          mem_rd,
   output logic                wb_regwrite,
   output logic                wb_memtoreg,
   output logic [4:0]          wb_rd,
   output logic                stall,
   output logic                flush,
   output logic [BUBBLE_W-1:0] bubble_cnt
);

   localparam int REG_WRITE  = 8;
   localparam int MEM_TO_REG = 7;
   localparam int MEM_READ   = 6;
   localparam int MEM_WRITE  = 5;
   localparam int BRANCH     = 3;
   localparam int JUMP       = 2;

   localparam logic [BUBBLE_W-1:0] CNT_MAX = '1;
   localparam logic [BUBBLE_W-1:0] CNT_ONE = {{(BUBBLE_W-1){1'b0}}, 1'b1};

   logic load_use;
   logic advance;

   // Hazards look only at the EX register and the ID inputs; a redirect
   // from EX makes the ID instruction dead, so it masks the load-use stall.
   always_comb begin
      flush    = (ex_ctrl[BRANCH] & ex_branch_taken) | ex_ctrl[JUMP];
      load_use = ex_ctrl[MEM_READ] && (ex_rd != 5'd0) && id_valid &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      stall    = load_use & ~flush;
      advance  = id_valid & ~stall & ~flush;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_ctrl      <= '0;
         ex_rd        <= '0;
         mem_regwrite <= 1'b0;
         mem_memtoreg <= 1'b0;
         mem_memread  <= 1'b0;
         mem_memwrite <= 1'b0;
         mem_rd       <= '0;
         wb_regwrite  <= 1'b0;
         wb_memtoreg  <= 1'b0;
         wb_rd        <= '0;
         bubble_cnt   <= '0;
      end else begin
         ex_ctrl      <= advance ? id_ctrl : 9'd0;
         ex_rd        <= advance ? id_rd : 5'd0;
         mem_regwrite <= ex_ctrl[REG_WRITE];
         mem_memtoreg <= ex_ctrl[MEM_TO_REG];
         mem_memread  <= ex_ctrl[MEM_READ];
         mem_memwrite <= ex_ctrl[MEM_WRITE];
         mem_rd       <= ex_rd;
         wb_regwrite  <= mem_regwrite;
         wb_memtoreg  <= mem_memtoreg;
         wb_rd        <= mem_rd;
         // Idle (id_valid=0) bubbles are deliberately left out of the count.
         if ((stall || flush) && (bubble_cnt != CNT_MAX))
            bubble_cnt <= bubble_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic
// against an instruction-level reference model; a narrow-counter instance covers saturation.
module tb_ctrl_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] id_ctrl;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_branch_taken;

   logic [8:0]  ex_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
   logic        wb_regwrite, wb_memtoreg, stall, flush;
   logic [15:0] bubble_cnt;

   logic [8:0]  s_ex_ctrl;
   logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
   logic        s_mem_regwrite, s_mem_memtoreg, s_mem_memread, s_mem_memwrite;
   logic        s_wb_regwrite, s_wb_memtoreg, s_stall, s_flush;
   logic [3:0]  s_bubble_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ctrl_pipe dut (
      .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
      .stall(stall), .flush(flush), .bubble_cnt(bubble_cnt)
   );

   // Narrow counter instance sharing the same stimulus, so saturation is reachable quickly.
   ctrl_pipe #(.BUBBLE_W(4)) dut_s (
      .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd), .mem_regwrite(s_mem_regwrite), .mem_memtoreg(s_mem_memtoreg),
      .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite), .mem_rd(s_mem_rd),
      .wb_regwrite(s_wb_regwrite), .wb_memtoreg(s_wb_memtoreg), .wb_rd(s_wb_rd),
      .stall(s_stall), .flush(s_flush), .bubble_cnt(s_bubble_cnt)
   );

   typedef struct packed {
      logic [8:0] ctrl;
      logic [4:0] rd;
   } instr_t;

   instr_t m_ex, m_mem, m_wb;
   int     m_bub;

   function automatic logic m_flush();
      return (m_ex.ctrl[3] && ex_branch_taken) || m_ex.ctrl[2];
   endfunction

   function automatic logic m_stall();
      return !m_flush() && m_ex.ctrl[6] && (m_ex.rd != 5'd0) && id_valid &&
             ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));
   endfunction

   function automatic logic [15:0] m_cnt16();
      return (m_bub > 65535) ? 16'hFFFF : 16'(m_bub);
   endfunction

   function automatic logic [3:0] m_cnt4();
      return (m_bub > 15) ? 4'hF : 4'(m_bub);
   endfunction

   // Advances the clock one edge and moves every in-flight instruction one stage on.
   task automatic tick();
      logic s, f;
      s = m_stall();
      f = m_flush();
      @(posedge clk);
      if (reset) begin
         m_ex = '0; m_mem = '0; m_wb = '0; m_bub = 0;
      end else begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (s || f) m_bub++;
         m_ex  = (id_valid && !s && !f) ? {id_ctrl, id_rd} : '0;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic tk);
      id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_branch_taken = tk;
   endtask

   task automatic drain();
      drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 9'h1FF, 5'd1, 5'd2, 5'd3, 1'b1);
      tick();
      tick();
      n_checks++;
      if ({ex_ctrl, ex_rd, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite, mem_rd,
           wb_regwrite, wb_memtoreg, wb_rd, bubble_cnt} !== 48'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got ex_ctrl=%b ex_rd=%0d mem_rd=%0d wb_rd=%0d cnt=%0d, expected all 0",
                  ex_ctrl, ex_rd, mem_rd, wb_rd, bubble_cnt);
      end
      reset = 1'b0;
      drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      n_checks++;
      if ({stall, flush} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL reset_hazards: got stall=%b flush=%b, expected 0 0", stall, flush);
      end
   endtask

   task automatic test_load_use();
      int b0;
      drain();
      drive(1'b1, 9'b111010000, 5'd0, 5'd0, 5'd5, 1'b0);
      tick();
      b0 = m_bub;
      drive(1'b1, 9'b100000010, 5'd5, 5'd3, 5'd6, 1'b0);
      #1;
      n_checks++;
      if ({stall, flush} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL load_use_stall: got stall=%b flush=%b, expected 1 0", stall, flush);
      end
      tick();
      n_checks++;
      if ({ex_ctrl, ex_rd} !== 14'd0 || bubble_cnt !== 16'(b0 + 1) ||
          mem_memread !== 1'b1 || mem_rd !== 5'd5) begin
         n_fail++;
         $display("[TB] FAIL load_use_bubble: got ex_ctrl=%b ex_rd=%0d cnt=%0d mem_memread=%b mem_rd=%0d, expected 0 0 %0d 1 5",
                  ex_ctrl, ex_rd, bubble_cnt, mem_memread, mem_rd, b0 + 1);
      end
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL load_use_single: got stall=%b, expected 0", stall);
      end
      tick();
      n_checks++;
      if (ex_ctrl !== 9'b100000010 || ex_rd !== 5'd6 || wb_regwrite !== 1'b1 ||
          wb_memtoreg !== 1'b1 || wb_rd !== 5'd5 || bubble_cnt !== 16'(b0 + 1)) begin
         n_fail++;
         $display("[TB] FAIL load_use_advance: got ex_ctrl=%b ex_rd=%0d wb=%b%b/%0d cnt=%0d, expected 100000010 6 11/5 %0d",
                  ex_ctrl, ex_rd, wb_regwrite, wb_memtoreg, wb_rd, bubble_cnt, b0 + 1);
      end
   endtask

   task automatic test_x0();
      drain();
      drive(1'b1, 9'b111010000, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      drive(1'b1, 9'b100000010, 5'd0, 5'd0, 5'd4, 1'b0);
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL x0_no_stall: got stall=%b, expected 0", stall);
      end
      tick();
      n_checks++;
      if (ex_ctrl !== 9'b100000010 || ex_rd !== 5'd4 || mem_rd !== 5'd0 || mem_memread !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL x0_advance: got ex_ctrl=%b ex_rd=%0d mem_rd=%0d mem_memread=%b, expected 100000010 4 0 1",
                  ex_ctrl, ex_rd, mem_rd, mem_memread);
      end
   endtask

   task automatic test_branch();
      int b0;
      drain();
      drive(1'b1, 9'b001001000, 5'd0, 5'd0, 5'd5, 1'b0);
      tick();
      drive(1'b1, 9'b100000010, 5'd5, 5'd0, 5'd8, 1'b0);
      #1;
      n_checks++;
      if ({stall, flush} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL branch_not_taken: got stall=%b flush=%b, expected 1 0", stall, flush);
      end
      ex_branch_taken = 1'b1;
      #1;
      n_checks++;
      if ({stall, flush} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL branch_taken_prio: got stall=%b flush=%b, expected 0 1", stall, flush);
      end
      b0 = m_bub;
      tick();
      n_checks++;
      if (ex_ctrl !== 9'd0 || bubble_cnt !== 16'(b0 + 1) || mem_memread !== 1'b1 || mem_rd !== 5'd5) begin
         n_fail++;
         $display("[TB] FAIL branch_flush: got ex_ctrl=%b cnt=%0d mem_memread=%b mem_rd=%0d, expected 0 %0d 1 5",
                  ex_ctrl, bubble_cnt, mem_memread, mem_rd, b0 + 1);
      end
   endtask

   task automatic test_jump();
      drain();
      drive(1'b1, 9'b100000100, 5'd0, 5'd0, 5'd1, 1'b0);
      tick();
      drive(1'b1, 9'b100010011, 5'd2, 5'd3, 5'd9, 1'b0);
      #1;
      n_checks++;
      if (flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL jump_flush_nt: got flush=%b, expected 1", flush);
      end
      ex_branch_taken = 1'b1;
      #1;
      n_checks++;
      if (flush !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL jump_flush_t: got flush=%b, expected 1", flush);
      end
      tick();
      n_checks++;
      if (ex_ctrl !== 9'd0 || mem_regwrite !== 1'b1 || mem_rd !== 5'd1) begin
         n_fail++;
         $display("[TB] FAIL jump_advance: got ex_ctrl=%b mem_regwrite=%b mem_rd=%0d, expected 0 1 1",
                  ex_ctrl, mem_regwrite, mem_rd);
      end
   endtask

   task automatic test_propagation();
      int b0;
      drain();
      b0 = m_bub;
      drive(1'b1, 9'b100010011, 5'd1, 5'd2, 5'd7, 1'b0);
      tick();
      n_checks++;
      if (ex_ctrl !== 9'b100010011 || ex_rd !== 5'd7) begin
         n_fail++;
         $display("[TB] FAIL prop_ex: got ex_ctrl=%b ex_rd=%0d, expected 100010011 7", ex_ctrl, ex_rd);
      end
      drive(1'b0, 9'h1FF, 5'd7, 5'd7, 5'd3, 1'b0);
      tick();
      n_checks++;
      if (mem_rd !== 5'd7 || mem_regwrite !== 1'b1 || ex_ctrl !== 9'd0 || bubble_cnt !== 16'(b0)) begin
         n_fail++;
         $display("[TB] FAIL prop_mem: got mem_rd=%0d mem_regwrite=%b ex_ctrl=%b cnt=%0d, expected 7 1 0 %0d",
                  mem_rd, mem_regwrite, ex_ctrl, bubble_cnt, b0);
      end
      tick();
      n_checks++;
      if (wb_rd !== 5'd7 || wb_regwrite !== 1'b1 || wb_memtoreg !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL prop_wb: got wb_rd=%0d wb_regwrite=%b wb_memtoreg=%b, expected 7 1 0",
                  wb_rd, wb_regwrite, wb_memtoreg);
      end
   endtask

   task automatic test_random();
      logic [49:0] obs, exp;
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(($urandom_range(0, 3) != 0), 9'($urandom), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
         #1;
         n_checks++;
         if ({stall, flush} !== {m_stall(), m_flush()}) begin
            n_fail++;
            $display("[TB] FAIL rand_hazard[%0d]: got stall=%b flush=%b, expected %b %b",
                     i, stall, flush, m_stall(), m_flush());
         end
         tick();
         obs = {ex_ctrl, ex_rd, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite, mem_rd,
                wb_regwrite, wb_memtoreg, wb_rd, bubble_cnt, s_bubble_cnt};
         exp = {m_ex.ctrl, m_ex.rd, m_mem.ctrl[8], m_mem.ctrl[7], m_mem.ctrl[6], m_mem.ctrl[5], m_mem.rd,
                m_wb.ctrl[8], m_wb.ctrl[7], m_wb.rd, m_cnt16(), m_cnt4()};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL rand_state[%0d]: got %h, expected %h", i, obs, exp);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      reset = 1'b1;
      drain();
      reset = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 9'b111010000, 5'd0, 5'd0, 5'd5, 1'b0);
         tick();
         drive(1'b1, 9'b100000010, 5'd5, 5'd5, 5'd6, 1'b0);
         tick();
         n_checks++;
         if (bubble_cnt !== 16'(i) || s_bubble_cnt !== ((i > 15) ? 4'hF : 4'(i))) begin
            n_fail++;
            $display("[TB] FAIL saturate[%0d]: got cnt=%0d narrow=%0d, expected %0d %0d",
                     i, bubble_cnt, s_bubble_cnt, i, (i > 15) ? 15 : i);
         end
      end
      drive(1'b1, 9'b111011000, 5'd0, 5'd0, 5'd7, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      n_checks++;
      if ({ex_ctrl, ex_rd, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite, mem_rd,
           wb_regwrite, wb_memtoreg, wb_rd, bubble_cnt, s_bubble_cnt, stall, flush} !== 54'd0) begin
         n_fail++;
         $display("[TB] FAIL midrun_reset: got ex_ctrl=%b wb_regwrite=%b cnt=%0d narrow=%0d stall=%b flush=%b, expected all 0",
                  ex_ctrl, wb_regwrite, bubble_cnt, s_bubble_cnt, stall, flush);
      end
      tick();
      n_checks++;
      if (wb_regwrite !== 1'b0 || mem_regwrite !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midrun_reset_wb: got wb_regwrite=%b mem_regwrite=%b, expected 0 0",
                  wb_regwrite, mem_regwrite);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      m_ex = '0; m_mem = '0; m_wb = '0; m_bub = 0;
      test_reset();
      test_load_use();
      test_x0();
      test_branch();
      test_jump();
      test_propagation();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
